// File: rtl/bch_syndrome_calc_pkg.sv
// Shared constants, types and GF(2^6) helpers for the BCH(63,51,t=2) receive path.
package bch63_pkg;

    localparam int unsigned N = 63;
    localparam int unsigned K = 51;
    localparam int unsigned M = 6;

    localparam logic [M:0] PRIM_POLY = 7'b1000011;

    typedef logic [M-1:0] gf64_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Multiply by alpha: shift left, fold x^6 back in as x+1.
    function automatic gf64_t gf_mul_alpha(input gf64_t a);
        gf64_t r;
        r = {a[M-2:0], 1'b0};
        if (a[M-1])
            r = r ^ PRIM_POLY[M-1:0];
        return r;
    endfunction

endpackage

// File: rtl/bch_syndrome_calc_horner_step.sv
// One Horner step for both syndrome accumulators: acc*alpha^j + b.
module gf64_horner_step
    import bch63_pkg::*;
(
    input  gf64_t i_acc1,
    input  gf64_t i_acc3,
    input  logic  i_bit,
    output gf64_t o_acc1,
    output gf64_t o_acc3
);

    gf64_t w_mul1;
    gf64_t w_mul3;

    // Three chained alpha steps collapse to pure XOR logic in one cycle.
    always_comb begin
        w_mul1 = gf_mul_alpha(i_acc1);
        w_mul3 = gf_mul_alpha(gf_mul_alpha(gf_mul_alpha(i_acc3)));
    end

    assign o_acc1 = {w_mul1[M-1:1], w_mul1[0] ^ i_bit};
    assign o_acc3 = {w_mul3[M-1:1], w_mul3[0] ^ i_bit};

endmodule

// File: rtl/bch_syndrome_calc.sv
// Serial MSB-first syndrome evaluator: S1 = r(alpha), S3 = r(alpha^3) over GF(2^6).
module bch_syndrome_calc
    import bch63_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] codeword,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] s1,
    output logic [M-1:0] s3,
    output logic         err_detected
);

    state_t       r_state;
    logic [N-1:0] r_word;
    logic [5:0]   r_cnt;
    gf64_t        r_acc1;
    gf64_t        r_acc3;
    logic         r_busy;
    logic         r_done;
    gf64_t        r_s1;
    gf64_t        r_s3;
    logic         r_err;

    logic         w_bit;
    gf64_t        w_acc1_nxt;
    gf64_t        w_acc3_nxt;

    assign w_bit = r_word[r_cnt];

    gf64_horner_step u_step (
        .i_acc1 (r_acc1),
        .i_acc3 (r_acc3),
        .i_bit  (w_bit),
        .o_acc1 (w_acc1_nxt),
        .o_acc3 (w_acc3_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_cnt   <= '0;
            r_acc1  <= '0;
            r_acc3  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s1    <= '0;
            r_s3    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_word  <= codeword;
                        r_acc1  <= '0;
                        r_acc3  <= '0;
                        r_cnt   <= 6'(N - 1);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc1 <= w_acc1_nxt;
                    r_acc3 <= w_acc3_nxt;
                    if (r_cnt == '0)
                        r_state <= DONE;
                    else
                        r_cnt <= r_cnt - 6'd1;
                end
                DONE: begin
                    r_s1    <= r_acc1;
                    r_s3    <= r_acc3;
                    r_err   <= (|r_acc1) | (|r_acc3);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign s1           = r_s1;
    assign s3           = r_s3;
    assign err_detected = r_err;

endmodule

// File: doc/bch_syndrome_calc.md
Name: bch_syndrome_calc

Overview:
- Receive-side stage placed directly downstream of BCHEncoder in the BCH(63,51,t=2) chain.
- Accepts one 63-bit codeword in parallel and evaluates it serially, MSB-first, by Horner's rule over GF(2^6), primitive polynomial x^6+x+1.
- Produces syndromes S1=r(α) and S3=r(α^3) plus an error flag.
- The future error locator/corrector consumes its outputs.

Parameters:
- N, 63, codeword length; fixed for this code.
- K, 51, message length; informational only, not used in logic.
- M, 6, GF field width; fixed.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- codeword  input  63  received word; bit i is the coefficient of x^i. Integration reverses BCHEncoder's out[0:62] so that out[0] lands on codeword[62].
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high while a codeword is being evaluated.
- done  output  1  one-cycle pulse when the syndromes update.
- s1  output  6  syndrome S1, polynomial basis, bit0 = α^0.
- s3  output  6  syndrome S3, same basis.
- err_detected  output  1  (s1!=0) | (s3!=0).

Behaviour:
- Reset (async, any state): state=IDLE; cnt=0; shift register and accumulators cleared; busy=0, done=0, s1=0, s3=0, err_detected=0.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - busy=0.
  - On start=1 at edge k: capture codeword into internal 63-bit register, clear acc1/acc3, set cnt=62, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), once per cycle:
  - b = reg[cnt].
  - acc1 <= acc1·α ⊕ b.
  - acc3 <= acc3·α^3 ⊕ b.
  - b is XORed into bit0 only.
  - If cnt==0, go to DONE; otherwise cnt <= cnt-1.
  - Exactly 63 SHIFT cycles.
- DONE (busy=1):
  - Register s1<=acc1, s3<=acc3, err_detected<=|acc1 | |acc3.
  - done=1 for this single cycle; go to IDLE.
- Latency: start sampled at edge k, busy high from k+1 through k+64, done and the new s1/s3 visible after edge k+64. Next start is accepted at edge k+65 at the earliest.
- Multiply by α: shift left 1; if bit5 was set, XOR 6'b000011.
- Multiply by α^3: three α-steps, flattened to combinational XOR logic (one cycle).
- s1/s3/err_detected hold their last values until the next DONE. They do not change during SHIFT.
- start while busy: ignored; no queueing.
- codeword changes during SHIFT: no effect, because it is captured at acceptance.
- Reset mid-SHIFT: abort immediately, all outputs 0, no done pulse.
- start held high continuously: back-to-back evaluations, one per 65 cycles.

Decomposition:
- Package bch63_pkg:
  - constants N=63, K=51, M=6.
  - primitive polynomial 7'b1000011.
  - typedef gf64_t (6-bit).
  - state enum {IDLE, SHIFT, DONE}.
- Sub-module gf64_horner_step (combinational): inputs acc and bit; outputs acc·α⊕bit and acc·α^3⊕bit. Instantiated once, feeding both accumulators.

Test Plan:
- All-zero codeword, start pulse:
  - done after 64 cycles.
  - s1=6'b000000, s3=6'b000000, err_detected=0.
- Single error at x^0 (codeword=1) -> s1=6'b000001, s3=6'b000001, err_detected=1.
- Single error at x^1 -> s1=6'b000010 (α), s3=6'b001000 (α^3).
- Single error at x^6 -> s1=6'b000011 (α^6), s3=6'b001111 (α^18).
- Double error at x^0 and x^1 -> s1=6'b000011, s3=6'b001001.
- Control corner cases:
  - Start pulsed again mid-SHIFT: ignored, done still at exactly k+64.
  - Assert reset at cycle k+30: busy=0 and no done pulse.
  - Restart: result correct for the new word.
  - Encoder loopback: codewords from BCHEncoder for 100 random messages give s1=s3=0.
